// File: rtl/axis_i2c_arbiter.sv
// Round-robin arbiter that lets N_REQ AXI-Stream requesters share one I2C master command port.
// One whole packet (up to tlast) is forwarded per grant. No new grant is issued until the
// master reports bus completion or the wait for completion times out.
module axis_i2c_arbiter #(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned TIMEOUT_CYC = 100000,
   localparam int unsigned IdxW       = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    arst,
   input  logic [N_REQ*DATA_W-1:0] s_axis_tdata,
   input  logic [N_REQ-1:0]        s_axis_tvalid,
   input  logic [N_REQ-1:0]        s_axis_tlast,
   output logic [N_REQ-1:0]        s_axis_tready,
   output logic [DATA_W-1:0]       m_axis_tdata,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   output logic [IdxW-1:0]         m_axis_tuser,
   input  logic                    m_axis_tready,
   input  logic                    i2c_done,
   output logic [N_REQ-1:0]        grant,
   output logic                    busy,
   output logic                    err_timeout
);

   typedef enum logic [1:0] {StIdle, StXfer, StWaitDone} state_e;

   state_e            state_q;
   logic [N_REQ-1:0]  grant_q;
   logic [IdxW-1:0]   gidx_q;
   logic [IdxW-1:0]   last_grant_q;
   logic [31:0]       cnt_q;
   logic              busy_q;
   logic              err_timeout_q;

   logic              pick_found;
   logic [IdxW-1:0]   pick_idx;
   logic              xfer_end;

   // Round-robin pick: first valid requester starting just after the last one granted
   always_comb begin : rr_pick
      int unsigned     cand;
      logic [IdxW-1:0] cand_idx;
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         cand     = (32'(last_grant_q) + k) % N_REQ;
         cand_idx = IdxW'(cand);
         if (!pick_found && s_axis_tvalid[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   // Combinational pass-through from the granted requester to the master, only while in XFER
   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = '0;
      s_axis_tready = '0;
      if (state_q == StXfer) begin
         m_axis_tdata          = s_axis_tdata[32'(gidx_q)*DATA_W +: DATA_W];
         m_axis_tvalid         = s_axis_tvalid[gidx_q];
         m_axis_tlast          = s_axis_tlast[gidx_q];
         m_axis_tuser          = gidx_q;
         s_axis_tready[gidx_q] = m_axis_tready;
      end
   end

   assign xfer_end = m_axis_tvalid & m_axis_tready & m_axis_tlast;

   // Arbitration FSM. grant, busy and err_timeout are registered alongside the state.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q       <= StIdle;
         grant_q       <= '0;
         gidx_q        <= '0;
         last_grant_q  <= IdxW'(N_REQ - 1);
         cnt_q         <= '0;
         busy_q        <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         err_timeout_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pick_found) begin
                  grant_q      <= N_REQ'(1) << pick_idx;
                  gidx_q       <= pick_idx;
                  last_grant_q <= pick_idx;
                  busy_q       <= 1'b1;
                  state_q      <= StXfer;
               end
            end
            StXfer: begin
               if (xfer_end) begin
                  cnt_q   <= '0;
                  state_q <= StWaitDone;
               end
            end
            StWaitDone: begin
               // Completion takes priority over a timeout landing on the same cycle
               if (i2c_done) begin
                  grant_q <= '0;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else if (cnt_q == 32'(TIMEOUT_CYC - 1)) begin
                  err_timeout_q <= 1'b1;
                  grant_q       <= '0;
                  busy_q        <= 1'b0;
                  state_q       <= StIdle;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            default: begin
               grant_q <= '0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign grant       = grant_q;
   assign busy        = busy_q;
   assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_axis_i2c_arbiter.sv
// Directed testbench for axis_i2c_arbiter (4 requesters, 8-bit data, 16-cycle timeout).
module tb_axis_i2c_arbiter;

   localparam int unsigned NReq  = 4;
   localparam int unsigned DataW = 8;
   localparam int unsigned ToCyc = 16;

   logic              clk = 1'b0;
   logic              arst;
   logic [31:0]       s_tdata;
   logic [3:0]        s_tvalid;
   logic [3:0]        s_tlast;
   logic [3:0]        s_tready;
   logic [7:0]        m_tdata;
   logic              m_tvalid;
   logic              m_tlast;
   logic [1:0]        m_tuser;
   logic              m_tready;
   logic              i2c_done;
   logic [3:0]        grant;
   logic              busy;
   logic              err;

   int n_pass  = 0;
   int n_total = 0;

   axis_i2c_arbiter #(
      .N_REQ       (NReq),
      .DATA_W      (DataW),
      .TIMEOUT_CYC (ToCyc)
   ) dut (
      .clk           (clk),
      .arst          (arst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tlast  (m_tlast),
      .m_axis_tuser  (m_tuser),
      .m_axis_tready (m_tready),
      .i2c_done      (i2c_done),
      .grant         (grant),
      .busy          (busy),
      .err_timeout   (err)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      s_tvalid = '0;
      s_tlast  = '0;
      s_tdata  = '0;
      m_tready = 1'b0;
      i2c_done = 1'b0;
      arst     = 1'b1;
      tick;
      tick;
      arst     = 1'b0;
   endtask

   task automatic test_reset;
      arst     = 1'b1;
      s_tvalid = 4'b1111;
      s_tlast  = 4'b1111;
      m_tready = 1'b1;
      i2c_done = 1'b0;
      s_tdata  = 32'h44332211;
      tick;
      n_total++;
      if (grant !== 4'b0000) $display("FAIL rst_grant: got %b want 0000", grant); else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
      n_total++;
      if (m_tvalid !== 1'b0) $display("FAIL rst_mvalid: got %b want 0", m_tvalid); else n_pass++;
      n_total++;
      if (s_tready !== 4'b0000) $display("FAIL rst_sready: got %b want 0000", s_tready);
      else n_pass++;
      n_total++;
      if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
      arst = 1'b0;
      tick;
      n_total++;
      if (grant !== 4'b0001) $display("FAIL rst_first_grant: got %b want 0001", grant);
      else n_pass++;
   endtask

   task automatic test_basic;
      apply_reset;
      m_tready      = 1'b1;
      s_tvalid[2]   = 1'b1;
      s_tdata[23:16] = 8'hA0;
      #1;
      n_total++;
      if (grant !== 4'b0000) $display("FAIL basic_pre_grant: got %b want 0000", grant);
      else n_pass++;
      tick;
      n_total++;
      if (grant !== 4'b0100) $display("FAIL basic_grant: got %b want 0100", grant); else n_pass++;
      n_total++;
      if (m_tdata !== 8'hA0 || m_tuser !== 2'd2 || m_tvalid !== 1'b1)
         $display("FAIL basic_beat0: got data %h user %0d valid %b want a0 2 1",
                  m_tdata, m_tuser, m_tvalid);
      else n_pass++;
      n_total++;
      if (s_tready !== 4'b0100) $display("FAIL basic_sready: got %b want 0100", s_tready);
      else n_pass++;
      tick;
      s_tdata[23:16] = 8'h10;
      #1;
      n_total++;
      if (m_tdata !== 8'h10 || m_tuser !== 2'd2)
         $display("FAIL basic_beat1: got %h/%0d want 10/2", m_tdata, m_tuser);
      else n_pass++;
      tick;
      s_tdata[23:16] = 8'h55;
      s_tlast[2]     = 1'b1;
      #1;
      n_total++;
      if (m_tdata !== 8'h55 || m_tlast !== 1'b1)
         $display("FAIL basic_beat2: got %h last %b want 55 last 1", m_tdata, m_tlast);
      else n_pass++;
      tick;
      s_tvalid = '0;
      s_tlast  = '0;
      #1;
      n_total++;
      if (m_tvalid !== 1'b0 || s_tready !== 4'b0000 || grant !== 4'b0100 || busy !== 1'b1)
         $display("FAIL basic_wait: got mvalid %b sready %b grant %b busy %b want 0 0000 0100 1",
                  m_tvalid, s_tready, grant, busy);
      else n_pass++;
      tick;
      tick;
      tick;
      n_total++;
      if (busy !== 1'b1) $display("FAIL basic_wait_hold: got busy %b want 1", busy); else n_pass++;
      i2c_done = 1'b1;
      tick;
      i2c_done = 1'b0;
      n_total++;
      if (busy !== 1'b0 || grant !== 4'b0000)
         $display("FAIL basic_done: got busy %b grant %b want 0 0000", busy, grant);
      else n_pass++;
   endtask

   task automatic test_round_robin;
      int unsigned exp_order[6] = '{0, 1, 3, 0, 1, 3};
      logic [3:0]  exp_g;
      apply_reset;
      m_tready = 1'b1;
      s_tvalid = 4'b1011;
      s_tlast  = 4'b1111;
      s_tdata  = 32'hD3C2B1A0;
      for (int i = 0; i < 6; i++) begin
         int w = 0;
         while (grant === 4'b0000 && w < 20) begin
            tick;
            w++;
         end
         exp_g = 4'b0001 << exp_order[i];
         n_total++;
         if (grant !== exp_g || m_tuser !== 2'(exp_order[i]))
            $display("FAIL rr_grant%0d: got grant %b user %0d want %b %0d",
                     i, grant, m_tuser, exp_g, exp_order[i]);
         else n_pass++;
         tick;
         repeat (4) tick;
         i2c_done = 1'b1;
         tick;
         i2c_done = 1'b0;
      end
   endtask

   task automatic test_backpressure;
      logic [7:0] beats[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic [7:0] rx[$];
      int         sent = 0;
      int         gap  = 0;
      int         bad  = 0;
      int         c    = 0;
      logic       acc;
      apply_reset;
      s_tvalid      = 4'b1101;
      s_tlast       = 4'b1100;
      s_tdata[7:0]  = beats[0];
      tick;
      while (rx.size() < 4 && c < 40) begin
         m_tready = (c % 2 == 0);
         #1;
         if (grant !== 4'b0001 || s_tready[3:1] !== 3'b000) bad++;
         if (m_tvalid && m_tready) rx.push_back(m_tdata);
         acc = s_tvalid[0] && s_tready[0];
         tick;
         c++;
         if (acc) begin
            sent++;
            if (sent == 1) gap = 3;
         end
         if (gap > 0) begin
            s_tvalid[0] = 1'b0;
            gap--;
         end else begin
            s_tvalid[0] = (sent < 4);
         end
         s_tdata[7:0] = (sent < 4) ? beats[sent] : 8'h00;
         s_tlast[0]   = (sent == 3);
      end
      n_total++;
      if (bad !== 0) $display("FAIL bp_grant_held: got %0d bad cycles want 0", bad); else n_pass++;
      n_total++;
      if (rx.size() !== 4) $display("FAIL bp_count: got %0d beats want 4", rx.size());
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         logic [7:0] got;
         got = (i < rx.size()) ? rx[i] : 8'hxx;
         n_total++;
         if (got !== beats[i]) $display("FAIL bp_beat%0d: got %h want %h", i, got, beats[i]);
         else n_pass++;
      end
      m_tready = 1'b1;
      #1;
      n_total++;
      if (busy !== 1'b1 || m_tvalid !== 1'b0 || s_tready !== 4'b0000)
         $display("FAIL bp_wait: got busy %b mvalid %b sready %b want 1 0 0000",
                  busy, m_tvalid, s_tready);
      else n_pass++;
      i2c_done = 1'b1;
      tick;
      i2c_done = 1'b0;
      tick;
      n_total++;
      if (grant !== 4'b0100) $display("FAIL bp_next_grant: got %b want 0100", grant);
      else n_pass++;
   endtask

   task automatic test_timeout;
      int early = 0;
      apply_reset;
      m_tready = 1'b1;
      s_tvalid = 4'b0010;
      s_tlast  = 4'b0010;
      tick;
      tick;
      // the single beat was accepted at this edge: WAIT_DONE entered
      s_tvalid = 4'b1000;
      s_tlast  = 4'b1000;
      for (int k = 1; k < 16; k++) begin
         tick;
         if (err !== 1'b0 || busy !== 1'b1) early++;
      end
      n_total++;
      if (early !== 0) $display("FAIL to_early: got %0d bad cycles want 0", early); else n_pass++;
      tick;
      n_total++;
      if (err !== 1'b1 || grant !== 4'b0000)
         $display("FAIL to_pulse: got err %b grant %b want 1 0000", err, grant);
      else n_pass++;
      tick;
      n_total++;
      if (err !== 1'b0 || grant !== 4'b1000)
         $display("FAIL to_after: got err %b grant %b want 0 1000", err, grant);
      else n_pass++;
   endtask

   task automatic test_collision;
      int errs = 0;
      apply_reset;
      m_tready = 1'b1;
      s_tvalid = 4'b0001;
      s_tlast  = 4'b0001;
      tick;
      tick;
      s_tvalid = '0;
      s_tlast  = '0;
      repeat (15) tick;
      i2c_done = 1'b1;
      tick;
      i2c_done = 1'b0;
      if (err !== 1'b0) errs++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL col_idle: got busy %b want 0", busy); else n_pass++;
      repeat (3) begin
         tick;
         if (err !== 1'b0) errs++;
      end
      n_total++;
      if (errs !== 0) $display("FAIL col_err: got %0d err cycles want 0", errs); else n_pass++;
   endtask

   task automatic test_reset_mid;
      apply_reset;
      m_tready       = 1'b1;
      s_tvalid       = 4'b0100;
      s_tdata[23:16] = 8'h01;
      tick;
      tick;
      s_tdata[23:16] = 8'h02;
      #2;
      arst = 1'b1;
      #1;
      n_total++;
      if (grant !== 4'b0000 || busy !== 1'b0 || err !== 1'b0)
         $display("FAIL mid_regs: got grant %b busy %b err %b want 0000 0 0", grant, busy, err);
      else n_pass++;
      n_total++;
      if (m_tvalid !== 1'b0 || m_tdata !== 8'h00 || m_tuser !== 2'd0 || m_tlast !== 1'b0 ||
          s_tready !== 4'b0000)
         $display("FAIL mid_stream: got mvalid %b data %h user %0d last %b sready %b want all 0",
                  m_tvalid, m_tdata, m_tuser, m_tlast, s_tready);
      else n_pass++;
      s_tvalid = 4'b1111;
      tick;
      arst = 1'b0;
      tick;
      n_total++;
      if (grant !== 4'b0001 || m_tuser !== 2'd0)
         $display("FAIL mid_first: got grant %b user %0d want 0001 0", grant, m_tuser);
      else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      arst     = 1'b1;
      s_tvalid = '0;
      s_tlast  = '0;
      s_tdata  = '0;
      m_tready = 1'b0;
      i2c_done = 1'b0;
      test_reset;
      test_basic;
      test_round_robin;
      test_backpressure;
      test_timeout;
      test_collision;
      test_reset_mid;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
